// File: rtl/td4_datapath_units.sv
// TD4 datapath primitives: 4-way 4-bit operand selector, 4-bit adder with
// carry-out, and the loadable 4-bit program counter that addresses the ROM.
module td4_datapath_units (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sel_c0,
  input  logic [3:0] sel_c1,
  input  logic [3:0] sel_c2,
  input  logic [3:0] sel_c3,
  input  logic       sel_a,
  input  logic       sel_b,
  output logic [3:0] sel_y,
  input  logic [3:0] add_a,
  input  logic [3:0] add_b,
  output logic [3:0] add_sum,
  output logic       add_co,
  input  logic       cnt_load,
  input  logic [3:0] cnt_din,
  output logic [3:0] cnt_q
);

  localparam int DATA_W = 4;

  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] r_cnt;

  // An unknown select bit falls through to the default and propagates X.
  always_comb begin
    case ({sel_b, sel_a})
      2'b00:   sel_y = sel_c0;
      2'b01:   sel_y = sel_c1;
      2'b10:   sel_y = sel_c2;
      2'b11:   sel_y = sel_c3;
      default: sel_y = 'x;
    endcase
  end

  assign w_sum   = {1'b0, add_a} + {1'b0, add_b};
  assign add_sum = w_sum[DATA_W-1:0];
  assign add_co  = w_sum[DATA_W];

  // Program counter: reset beats load, load beats the modulo-16 increment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (cnt_load) begin
      r_cnt <= cnt_din;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign cnt_q = r_cnt;

endmodule

// File: tb/tb_td4_datapath_units.sv
// Self-checking bench for td4_datapath_units: directed literal checks plus
// randomized cycles compared against a behavioural model every negedge.
module tb_td4_datapath_units;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sel_c0, sel_c1, sel_c2, sel_c3;
  logic       sel_a, sel_b;
  logic [3:0] sel_y;
  logic [3:0] add_a, add_b, add_sum;
  logic       add_co;
  logic       cnt_load;
  logic [3:0] cnt_din, cnt_q;

  int n_vec = 0;
  int n_err = 0;

  int  exp_cnt   = 0;
  bit  cnt_known = 1'b0;

  td4_datapath_units dut (
    .clk(clk), .reset(reset),
    .sel_c0(sel_c0), .sel_c1(sel_c1), .sel_c2(sel_c2), .sel_c3(sel_c3),
    .sel_a(sel_a), .sel_b(sel_b), .sel_y(sel_y),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_co(add_co),
    .cnt_load(cnt_load), .cnt_din(cnt_din), .cnt_q(cnt_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural counter model: a ROM address that clears, loads, or steps mod 16.
  always @(posedge clk) begin
    if (reset === 1'b0) begin
      exp_cnt   <= 0;
      cnt_known <= 1'b1;
    end else if (cnt_known) begin
      exp_cnt   <= (cnt_load === 1'b1) ? int'(cnt_din) : (exp_cnt + 1) % 16;
    end
  end

  // Compare process: all outputs checked against the model on every negedge.
  always @(negedge clk) begin
    logic [3:0] choices [4];
    int idx;
    int sum;
    choices[0] = sel_c0; choices[1] = sel_c1; choices[2] = sel_c2; choices[3] = sel_c3;
    idx = (sel_b ? 2 : 0) + (sel_a ? 1 : 0);
    sum = int'(add_a) + int'(add_b);
    check("model_sel_y", {1'b0, sel_y}, {1'b0, choices[idx]});
    check("model_add", {add_co, add_sum}, sum[4:0]);
    if (cnt_known) check("model_cnt_q", {1'b0, cnt_q}, exp_cnt[4:0]);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0; cnt_load = 1'b0; cnt_din = 4'd0;
    sel_c0 = 4'd1; sel_c1 = 4'd2; sel_c2 = 4'd4; sel_c3 = 4'd8;
    sel_a = 1'b0; sel_b = 1'b0; add_a = 4'd0; add_b = 4'd0;

    tick();
    check("reset_clears", {1'b0, cnt_q}, 5'd0);

    // Selector sweep while reset is held low.
    for (int s = 0; s < 4; s++) begin
      {sel_b, sel_a} = s[1:0];
      #1;
      check("sel_sweep", {1'b0, sel_y}, 5'd1 << s);
      tick();
      check("cnt_held_in_reset", {1'b0, cnt_q}, 5'd0);
    end

    reset = 1'b1;
    tick(); check("count_1", {1'b0, cnt_q}, 5'd1);
    tick(); check("count_2", {1'b0, cnt_q}, 5'd2);
    tick(); check("count_3", {1'b0, cnt_q}, 5'd3);
    repeat (13) tick();
    check("wrap_to_0", {1'b0, cnt_q}, 5'd0);

    cnt_load = 1'b1; cnt_din = 4'd5;  tick(); check("load_5", {1'b0, cnt_q}, 5'd5);
    cnt_din = 4'b1010;                tick(); check("load_10", {1'b0, cnt_q}, 5'd10);
    cnt_load = 1'b0;                  tick(); check("after_load_11", {1'b0, cnt_q}, 5'd11);
    cnt_load = 1'b1; cnt_din = 4'd15; tick(); check("load_15", {1'b0, cnt_q}, 5'd15);
    cnt_din = 4'd3;                   tick(); check("load_beats_wrap", {1'b0, cnt_q}, 5'd3);

    cnt_din = 4'd9; reset = 1'b0;     tick(); check("reset_beats_load", {1'b0, cnt_q}, 5'd0);
    reset = 1'b1; cnt_din = 4'd7;     tick(); check("load_7", {1'b0, cnt_q}, 5'd7);
    cnt_load = 1'b0; reset = 1'b0;    tick(); check("reset_mid_count", {1'b0, cnt_q}, 5'd0);
    reset = 1'b1;                     tick(); check("restart_1", {1'b0, cnt_q}, 5'd1);

    add_a = 4'd3;  add_b = 4'd4;  #1; check("add_3_4", {add_co, add_sum}, 5'b0_0111);
    tick();
    add_a = 4'd15; add_b = 4'd1;  #1; check("add_15_1", {add_co, add_sum}, 5'b1_0000);
    tick();
    add_a = 4'd15; add_b = 4'd15; #1; check("add_15_15", {add_co, add_sum}, 5'b1_1110);
    tick();
    add_a = 4'd0;  add_b = 4'd0;  #1; check("add_0_0", {add_co, add_sum}, 5'b0_0000);
    tick();

    // CPU-style chain: register A through the selector into the ALU.
    sel_c0 = 4'd2; {sel_b, sel_a} = 2'b00;
    #1; add_a = sel_y; add_b = 4'd1;
    #1; check("chain_alu", {add_co, add_sum}, 5'd3);
    tick();
    add_a = 4'd2;
    tick();

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        add_a = a[3:0]; add_b = b[3:0];
        #1;
        check("add_sweep", {add_co, add_sum}, 5'(a + b));
        tick();
      end
    end

    for (int i = 0; i < 2000; i++) begin
      reset    = ($urandom_range(0, 19) != 0);
      cnt_load = ($urandom_range(0, 4) == 0);
      cnt_din  = 4'($urandom);
      sel_c0 = 4'($urandom); sel_c1 = 4'($urandom);
      sel_c2 = 4'($urandom); sel_c3 = 4'($urandom);
      sel_a  = 1'($urandom); sel_b  = 1'($urandom);
      add_a  = 4'($urandom); add_b  = 4'($urandom);
      tick();
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/td4_datapath_units.md
# td4_datapath_units

Bundle of the three arithmetic/steering primitives used by the TD4 4-bit CPU datapath: a 4-input 4-bit data selector, a 4-bit adder with carry-out, and a 4-bit loadable program counter. The selector picks the ALU operand (register A, register B, input port, zero), the adder serves as the ALU (operand + immediate), and the counter drives the ROM address. The selector and adder are purely combinational; only the counter holds state.

## Interface
Parameters:
- none; all widths are fixed at 4 bits.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset: sampled on rising clk; reset=0 clears the counter.
- sel_c0, sel_c1, sel_c2, sel_c3  input  4 each  selector data inputs.
- sel_a  input  1  select bit 0 (LSB).
- sel_b  input  1  select bit 1 (MSB).
- sel_y  output  4  selected data.
- add_a  input  4  adder operand A (selector output in the CPU).
- add_b  input  4  adder operand B (immediate field in the CPU).
- add_sum  output  4  low 4 bits of add_a + add_b.
- add_co  output  1  carry out of the 4-bit addition.
- cnt_load  input  1  active-high synchronous load enable.
- cnt_din  input  4  value loaded when cnt_load=1.
- cnt_q  output  4  current counter value (ROM address).

## Operation
- Data selector: sel_y = sel_c0 when {sel_b,sel_a}=00, sel_c1 for 01, sel_c2 for 10, sel_c3 for 11. Purely combinational, no latching; any X on a select bit yields X on sel_y.
- Adder: {add_co, add_sum} = add_a + add_b, unsigned 5-bit result. add_co=1 exactly when the true sum exceeds 15. No carry-in.
- Counter, evaluated at every rising clk edge, in priority order:
  - reset=0: cnt_q <= 4'b0000 (cnt_load and cnt_din ignored).
  - else cnt_load=1: cnt_q <= cnt_din.
  - else: cnt_q <= cnt_q + 1, modulo 16 (4'b1111 wraps to 4'b0000; no carry/overflow flag).
- Counter has no enable other than reset/load; it advances on every non-reset, non-load edge.
- Reset affects only the counter; the selector and adder outputs track their inputs at all times, including during reset.

## Timing
- sel_y, add_sum, add_co: zero-cycle combinational paths from their inputs; no registers.
- cnt_q: changes only just after a rising clk edge; one-cycle latency from cnt_load/cnt_din/reset to cnt_q.
- Reset value: cnt_q = 0 after the first rising edge with reset=0. Before the first reset edge cnt_q is undefined.
- Reset released (reset=1) at an edge: that edge already acts as a normal count/load edge; first post-reset edge with cnt_load=0 yields cnt_q=1.
- Reset asserted mid-sequence: next edge forces 0 regardless of load; count restarts from 0 after release.
- Load and wrap coincide (cnt_q=15, cnt_load=1): load wins, cnt_q <= cnt_din.
- No combinational path from any counter input to cnt_q.

## Test plan
- Reset/count: reset=0 for one edge -> cnt_q=0; release with cnt_load=0 -> cnt_q=1,2,3… on successive edges; after 16 edges from 0 -> cnt_q back to 0 (wrap 15->0).
- Load: cnt_q=5, cnt_load=1, cnt_din=4'b1010 -> next edge cnt_q=10; drop load -> next edge 11. At cnt_q=15 with load of 3 -> 3, not 0.
- Reset priority: cnt_load=1, cnt_din=9, reset=0 at same edge -> cnt_q=0; reset asserted while counting at 7 -> 0 next edge.
- Selector sweep: c0=1, c1=2, c2=4, c3=8; {b,a}=00,01,10,11 -> sel_y=1,2,4,8 immediately, no clock needed; holds during reset=0.
- Adder: 3+4 -> sum=7, co=0; 15+1 -> sum=0, co=1; 15+15 -> sum=14, co=1; 0+0 -> sum=0, co=0; exhaustive 256-pair sweep matches a+b.
- CPU-style chain: sel_c0=A=2 selected ({b,a}=00), add_b=immediate 1 -> add_sum=3, co=0, while counter increments each edge unaffected.
